// File: rtl/armstrong_pkg.sv
// -----------------------------------------------------------------------------
// armstrong_pkg
// Shared types and constants for the Armstrong scan master.
//   armstrong_state_e : bus-sequencer state encoding (also exposed for debug)
//   NUM_W_DEF/DATA_W_DEF : default widths of scanned numbers / peripheral bus
//   STROBE_*          : strobe patterns packed as {chip_select_n, write_n, read_n}
//   strobe_for()      : maps a sequencer state to its strobe pattern
// -----------------------------------------------------------------------------
package armstrong_pkg;

    localparam int NUM_W_DEF  = 10;
    localparam int DATA_W_DEF = 16;

    // {chip_select_n, write_n, read_n}
    localparam logic [2:0] STROBE_IDLE    = 3'b111;
    localparam logic [2:0] STROBE_WRITE   = 3'b001;
    localparam logic [2:0] STROBE_COMPUTE = 3'b011;
    // The read strobe is issued with chip select released.
    localparam logic [2:0] STROBE_READ    = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_READ    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_FINISH  = 3'd5
    } armstrong_state_e;

    function automatic logic [2:0] strobe_for(input armstrong_state_e st);
        case (st)
            ST_WRITE:   return STROBE_WRITE;
            ST_COMPUTE: return STROBE_COMPUTE;
            ST_READ:    return STROBE_READ;
            default:    return STROBE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/armstrong_scan_master_if.sv
// -----------------------------------------------------------------------------
// armstrong_scan_master_if
// Peripheral bus between the scan master and an Armstrong-check peripheral.
//   oChip_select_n, oWrite_n, oRead_n : active-low strobes (master -> slave)
//   oData                             : write data, zero-extended number
//   iData                             : read data, only bit 0 carries meaning
// Bus protocol: the master writes a number with cs_n=0/write_n=0 for one
// cycle, keeps cs_n=0 for the compute window, then pulses read_n=0 for one
// cycle; the slave must present its result on iData in the following cycle.
// -----------------------------------------------------------------------------
interface armstrong_scan_master_if
    import armstrong_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              oChip_select_n;
    logic              oWrite_n;
    logic              oRead_n;
    logic [DATA_W-1:0] oData;
    logic [DATA_W-1:0] iData;

    modport master (
        output oChip_select_n,
        output oWrite_n,
        output oRead_n,
        output oData,
        input  iData
    );

    modport slave (
        input  oChip_select_n,
        input  oWrite_n,
        input  oRead_n,
        input  oData,
        output iData
    );
endinterface

// File: rtl/armstrong_bus_seq.sv
// -----------------------------------------------------------------------------
// armstrong_bus_seq
// Scan state machine, compute-window counter and registered strobe generator.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start_i        : scan request, only honoured in IDLE
//   range_ok_i     : range_lo <= range_hi (decides WRITE vs. straight FINISH)
//   last_i         : current number equals the upper bound
//   state_q_o      : current state (debug and datapath control)
//   state_d_o      : next state (lets the datapath register outputs early)
//   busy_o, done_o : registered status
//   cs_n_o, we_n_o, re_n_o : registered active-low strobes
// COMPUTE_CYCLES must lie in 1..15 (4-bit counter).
// -----------------------------------------------------------------------------
module armstrong_bus_seq
    import armstrong_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             range_ok_i,
    input  logic             last_i,
    output armstrong_state_e state_q_o,
    output armstrong_state_e state_d_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cs_n_o,
    output logic             we_n_o,
    output logic             re_n_o
);

    localparam logic [3:0] CNT_LOAD = 4'(COMPUTE_CYCLES - 1);

    armstrong_state_e state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = range_ok_i ? ST_WRITE : ST_FINISH;
                end
            end
            ST_WRITE: begin
                state_d = ST_COMPUTE;
                // COMPUTE then counts CNT_LOAD..0, i.e. COMPUTE_CYCLES cycles.
                cnt_d   = CNT_LOAD;
            end
            ST_COMPUTE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = last_i ? ST_FINISH : ST_WRITE;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        strobe_d = strobe_for(state_d);
        busy_d   = (state_d == ST_WRITE)   || (state_d == ST_COMPUTE) ||
                   (state_d == ST_READ)    || (state_d == ST_CAPTURE);
        done_d   = (state_d == ST_FINISH);
    end

    // Async reset releases the strobes immediately, without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q <= STROBE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign state_q_o = state_q;
    assign state_d_o = state_d;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cs_n_o    = strobe_q[2];
    assign we_n_o    = strobe_q[1];
    assign re_n_o    = strobe_q[0];

endmodule

// File: rtl/armstrong_scan_master.sv
// -----------------------------------------------------------------------------
// armstrong_scan_master
// Walks every number in [range_lo, range_hi] through an external Armstrong
// peripheral and counts the hits.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : one-cycle scan request, sampled only when idle
//   range_lo, range_hi    : inclusive bounds, captured on an accepted start
//   busy                  : high from the cycle after an accepted start up to
//                           (not including) the done cycle
//   done                  : one-cycle completion pulse
//   hit_count             : saturating hit count of the last scan
//   hit_valid, hit_number : one-cycle hit report
//   dbg_state_o           : sequencer state for observation
//   bus                   : peripheral bus (master modport)
// Handshake: start is a request pulse; it is accepted only while the block is
// idle, busy then rises and stays high until the cycle done pulses. Requests
// during busy are dropped, not queued.
// Build option: define ARMSTRONG_HIT_REPORT_EN to build the hit report
// registers; otherwise hit_valid/hit_number are tied to zero.
// -----------------------------------------------------------------------------
module armstrong_scan_master
    import armstrong_pkg::*;
#(
    parameter int NUM_W          = NUM_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int COMPUTE_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_W-1:0]         range_lo,
    input  logic [NUM_W-1:0]         range_hi,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_W:0]           hit_count,
    output logic                     hit_valid,
    output logic [NUM_W-1:0]         hit_number,
    output armstrong_state_e         dbg_state_o,
    armstrong_scan_master_if.master  bus
);

    armstrong_state_e  state_q, state_d;
    logic              accept, capture, last, range_ok, hit;
    logic [NUM_W:0]    num_q, num_d;        // one spare bit: no wrap at 2^NUM_W-1
    logic [NUM_W-1:0]  hi_q, hi_d;
    logic [NUM_W:0]    hit_count_q, hit_count_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              seq_cs_n, seq_we_n, seq_re_n;
    logic              unused_idata;

    assign accept   = (state_q == ST_IDLE) && start;
    assign capture  = (state_q == ST_CAPTURE);
    assign range_ok = (range_lo <= range_hi);
    assign last     = (num_q == {1'b0, hi_q});
    assign hit      = capture && bus.iData[0];

    // Only bit 0 of the read data carries the peripheral's verdict.
    assign unused_idata = ^bus.iData[DATA_W-1:1];

    armstrong_bus_seq #(
        .COMPUTE_CYCLES (COMPUTE_CYCLES)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .range_ok_i (range_ok),
        .last_i     (last),
        .state_q_o  (state_q),
        .state_d_o  (state_d),
        .busy_o     (busy),
        .done_o     (done),
        .cs_n_o     (seq_cs_n),
        .we_n_o     (seq_we_n),
        .re_n_o     (seq_re_n)
    );

    always_comb begin
        num_d       = num_q;
        hi_d        = hi_q;
        hit_count_d = hit_count_q;
        odata_d     = odata_q;
        if (accept) begin
            num_d       = {1'b0, range_lo};
            hi_d        = range_hi;
            hit_count_d = '0;
        end else if (capture) begin
            if (!last) begin
                num_d = num_q + (NUM_W+1)'(1);
            end
            if (bus.iData[0] && (hit_count_q != {(NUM_W+1){1'b1}})) begin
                hit_count_d = hit_count_q + (NUM_W+1)'(1);
            end
        end
        // Load write data together with entering WRITE so it is valid
        // for the whole write cycle.
        if (state_d == ST_WRITE) begin
            odata_d = DATA_W'(num_d[NUM_W-1:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q       <= '0;
            hi_q        <= '0;
            hit_count_q <= '0;
            odata_q     <= '0;
        end else begin
            num_q       <= num_d;
            hi_q        <= hi_d;
            hit_count_q <= hit_count_d;
            odata_q     <= odata_d;
        end
    end

`ifdef ARMSTRONG_HIT_REPORT_EN
    logic             hit_valid_q;
    logic [NUM_W-1:0] hit_number_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_valid_q  <= 1'b0;
            hit_number_q <= '0;
        end else begin
            hit_valid_q <= hit;
            if (hit) begin
                hit_number_q <= num_q[NUM_W-1:0];
            end
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit_number = hit_number_q;
`else
    logic unused_hit;
    assign unused_hit = hit;
    assign hit_valid  = 1'b0;
    assign hit_number = '0;
`endif

    assign hit_count          = hit_count_q;
    assign dbg_state_o        = state_q;
    assign bus.oChip_select_n = seq_cs_n;
    assign bus.oWrite_n       = seq_we_n;
    assign bus.oRead_n        = seq_re_n;
    assign bus.oData          = odata_q;

endmodule

// File: tb/tb_armstrong_scan_master.sv
// -----------------------------------------------------------------------------
// tb_armstrong_scan_master
// Directed bench for armstrong_scan_master with a behavioural peripheral that
// reports whether the sum of cubes of a number's decimal digits equals it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_armstrong_scan_master;
    import armstrong_pkg::*;

    localparam int NUM_W  = 10;
    localparam int DATA_W = 16;
    localparam int CC     = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             start;
    logic [NUM_W-1:0] range_lo, range_hi;
    logic             busy, done, hit_valid;
    logic [NUM_W:0]   hit_count;
    logic [NUM_W-1:0] hit_number;
    armstrong_state_e dbg_state;

    armstrong_scan_master_if #(.DATA_W(DATA_W)) bus ();

    armstrong_scan_master #(
        .NUM_W          (NUM_W),
        .DATA_W         (DATA_W),
        .COMPUTE_CYCLES (CC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .range_lo    (range_lo),
        .range_hi    (range_hi),
        .busy        (busy),
        .done        (done),
        .hit_count   (hit_count),
        .hit_valid   (hit_valid),
        .hit_number  (hit_number),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    // ---------------- peripheral model ----------------
    function automatic logic is_cube_sum(input logic [NUM_W-1:0] n);
        int v, s, d;
        v = int'(n);
        s = 0;
        while (v > 0) begin
            d = v % 10;
            s = s + d * d * d;
            v = v / 10;
        end
        return (s == int'(n));
    endfunction

    logic [NUM_W-1:0] periph_num;
    always @(posedge clk or posedge reset) begin
        logic [DATA_W-1:0] rd;
        if (reset) begin
            periph_num <= '0;
            bus.iData  <= '0;
        end else begin
            if (!bus.oChip_select_n && !bus.oWrite_n) begin
                periph_num <= bus.oData[NUM_W-1:0];
            end
            if (!bus.oRead_n) begin
                rd        = DATA_W'($urandom);  // junk in unused upper bits
                rd[0]     = is_cube_sum(periph_num);
                bus.iData <= rd;
            end
        end
    end

    // ---------------- monitor ----------------
    int               n_cmp = 0;
    int               n_err = 0;
    int               done_cnt = 0;
    int               busy_cyc = 0;
    int               lat = -1;
    int               strobe_act = 0;
    int               overlap_cnt = 0;
    int               hit_rpt_bad = 0;
    logic             in_scan = 1'b0;
    logic [NUM_W-1:0] hit_log[$];
    logic [2:0]       strobe_log[$];
    logic [NUM_W-1:0] exp_q[$];
    logic [2:0]       pat[6];

    always @(negedge clk) begin
        logic [2:0] s;
        if (!reset) begin
            s = {bus.oChip_select_n, bus.oWrite_n, bus.oRead_n};
            if (!bus.oWrite_n && !bus.oRead_n) overlap_cnt++;
            if (s != STROBE_IDLE) strobe_act++;
            if (busy) begin
                strobe_log.push_back(s);
                if (!in_scan) begin
                    in_scan  = 1'b1;
                    busy_cyc = 1;
                end else begin
                    busy_cyc++;
                end
            end
            if (done) begin
                done_cnt++;
                lat      = busy_cyc + 1;
                in_scan  = 1'b0;
                busy_cyc = 0;
            end
            if (hit_valid) hit_log.push_back(hit_number);
`ifndef ARMSTRONG_HIT_REPORT_EN
            if (hit_valid !== 1'b0 || hit_number !== '0) hit_rpt_bad++;
`endif
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic kick(input int lo, input int hi);
        @(negedge clk);
        done_cnt   = 0;
        strobe_act = 0;
        lat        = -1;
        in_scan    = 1'b0;
        busy_cyc   = 0;
        hit_log.delete();
        strobe_log.delete();
        range_lo = NUM_W'(lo);
        range_hi = NUM_W'(hi);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_hits(input string tag);
`ifdef ARMSTRONG_HIT_REPORT_EN
        check({tag, "_hits_n"}, 32'(hit_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < hit_log.size(); i++) begin
            check($sformatf("%s_hit%0d", tag, i), 32'(hit_log[i]), 32'(exp_q[i]));
        end
`else
        check({tag, "_hits_n"}, 32'(hit_log.size()), 32'd0);
        check({tag, "_hit_quiet"}, 32'(hit_rpt_bad), 32'd0);
`endif
    endtask

    task automatic set_full_hits();
        exp_q.delete();
        exp_q.push_back(10'd0);
        exp_q.push_back(10'd1);
        exp_q.push_back(10'd153);
        exp_q.push_back(10'd370);
        exp_q.push_back(10'd371);
        exp_q.push_back(10'd407);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        pat[0] = STROBE_WRITE;
        pat[1] = STROBE_COMPUTE;
        pat[2] = STROBE_COMPUTE;
        pat[3] = STROBE_COMPUTE;
        pat[4] = STROBE_READ;
        pat[5] = STROBE_IDLE;

        reset    = 1'b1;
        start    = 1'b0;
        range_lo = '0;
        range_hi = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state",      32'(dbg_state), 32'(ST_IDLE));
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_done",       32'(done), 32'd0);
        check("rst_hit_count",  32'(hit_count), 32'd0);
        check("rst_hit_valid",  32'(hit_valid), 32'd0);
        check("rst_hit_number", 32'(hit_number), 32'd0);
        check("rst_odata",      32'(bus.oData), 32'd0);
        check("rst_strobes",    32'({bus.oChip_select_n, bus.oWrite_n, bus.oRead_n}), 32'(3'b111));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 150..160: one hit (153), 11*6+1 cycles
        kick(150, 160);
        wait_done("r150", 200);
        exp_q.delete();
        exp_q.push_back(10'd153);
        check("r150_hit_count", 32'(hit_count), 32'd1);
        check("r150_latency",   32'(lat), 32'd67);
        check("r150_done_cnt",  32'(done_cnt), 32'd1);
        check_hits("r150");

        // Empty range: done next cycle, no bus activity
        kick(20, 10);
        wait_done("empty", 0);
        check("empty_hit_count", 32'(hit_count), 32'd0);
        check("empty_latency",   32'(lat), 32'd1);
        check("empty_strobes",   32'(strobe_act), 32'd0);
        check("empty_done_cnt",  32'(done_cnt), 32'd1);

        // 370..371 with an ignored second start mid-scan
        kick(370, 371);
        repeat (3) @(negedge clk);
        range_lo = '0;
        range_hi = 10'd1023;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done("r370", 100);
        exp_q.delete();
        exp_q.push_back(10'd370);
        exp_q.push_back(10'd371);
        check("r370_hit_count", 32'(hit_count), 32'd2);
        check("r370_latency",   32'(lat), 32'd13);
        check("r370_done_cnt",  32'(done_cnt), 32'd1);
        check("r370_log_n",     32'(strobe_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < strobe_log.size(); i++) begin
            check($sformatf("r370_strobe%0d", i), 32'(strobe_log[i]), 32'(pat[i % 6]));
        end
        check_hits("r370");

        // Full 0..1023 scan: no wrap past the top, exactly one done
        kick(0, 1023);
        wait_done("full", 7000);
        set_full_hits();
        check("full_hit_count", 32'(hit_count), 32'd6);
        check("full_latency",   32'(lat), 32'd6145);
        check("full_done_cnt",  32'(done_cnt), 32'd1);
        check_hits("full");
        repeat (4) @(negedge clk);
        check("full_no_rescan", 32'(busy), 32'd0);

        // Reset while in COMPUTE, strobes must release before the next edge
        kick(0, 1023);
        repeat (18) @(negedge clk);
        for (int i = 0; i < 20 && dbg_state != ST_COMPUTE; i++) @(negedge clk);
        check("mid_in_compute", 32'(dbg_state), 32'(ST_COMPUTE));
        check("mid_hit_count",  32'(hit_count), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_strobes", 32'({bus.oChip_select_n, bus.oWrite_n, bus.oRead_n}), 32'(3'b111));
        check("mid_rst_busy",    32'(busy), 32'd0);
        check("mid_rst_hits",    32'(hit_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle",  32'(dbg_state), 32'(ST_IDLE));
        check("post_rst_busy",  32'(busy), 32'd0);

        kick(0, 1023);
        wait_done("rerun", 7000);
        set_full_hits();
        check("rerun_hit_count", 32'(hit_count), 32'd6);
        check("rerun_latency",   32'(lat), 32'd6145);
        check("rerun_done_cnt",  32'(done_cnt), 32'd1);
        check_hits("rerun");

        check("rw_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/armstrong_scan_master.md
ARMSTRONG_SCAN_MASTER -- requirements
Module: armstrong_scan_master

Interface
REQ-001 Parameter NUM_W, default 10, width of scanned numbers.
REQ-002 Parameter DATA_W, default 16, peripheral data bus width.
REQ-003 Parameter COMPUTE_CYCLES, default 3, idle-select cycles given to the peripheral per number; legal range 1..15.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-007 range_lo / range_hi  input  NUM_W each  inclusive scan bounds; captured on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  one-cycle pulse at scan completion.
REQ-010 hit_count  output  NUM_W+1  number of Armstrong hits in the last scan; held until the next accepted start.
REQ-011 hit_valid / hit_number  output  1 / NUM_W  one-cycle hit report and the hit value.
REQ-012 oChip_select_n, oWrite_n, oRead_n  output  1 each  active-low peripheral strobes.
REQ-013 oData  output  DATA_W  write data, {zeros, current number}.
REQ-014 iData  input  DATA_W  peripheral read data; only bit 0 is used.

Function
REQ-015 States: IDLE, WRITE, COMPUTE, READ, CAPTURE, FINISH.
- IDLE->WRITE on start when range_lo<=range_hi.
- IDLE->FINISH on start when range_lo>range_hi.
REQ-016 WRITE: single cycle; oChip_select_n=0, oWrite_n=0, oData=current number; next state COMPUTE.
REQ-017 COMPUTE: oChip_select_n=0, oWrite_n=1, oRead_n=1 for exactly COMPUTE_CYCLES cycles, timed by a 4-bit down-counter; next state READ.
REQ-018 READ: single cycle; oRead_n=0, oChip_select_n=1; next state CAPTURE.
REQ-019 CAPTURE: iData[0] is sampled.
- If iData[0]=1: hit_count increments, and hit_valid pulses with hit_number equal to the current number.
- If current number==range_hi: next state FINISH.
- Otherwise: number increments and next state is WRITE.
REQ-020 FINISH: done=1 and busy=0 for one cycle; next state IDLE.
REQ-021 Per-number latency is COMPUTE_CYCLES+3 cycles; a full scan takes (range_hi-range_lo+1)*(COMPUTE_CYCLES+3)+1 cycles from the first busy cycle to done.
REQ-022 The number register is NUM_W+1 bits wide, so range_hi=2^NUM_W-1 terminates without wrap to 0.
REQ-023 hit_count saturates at its maximum and never wraps.
REQ-024 start while busy is ignored; range inputs are not re-sampled during a scan.
REQ-025 Every strobe is deasserted (1) in IDLE and FINISH; oWrite_n and oRead_n are never low in the same cycle.
REQ-026 All outputs are registered: no combinational path from any input to any output.

Reset
REQ-027 Reset forces:
- state=IDLE;
- busy=0, done=0, hit_valid=0;
- hit_count=0, hit_number=0, oData=0;
- all strobes=1.
REQ-028 Reset asserted mid-scan deasserts the strobes immediately, without waiting for a clock edge; after release the block waits for a new start.

Configuration
REQ-029 Macro ARMSTRONG_HIT_REPORT_EN.
- Defined: hit_valid and hit_number behave per REQ-019.
- Undefined: hit_valid and hit_number are tied to 0 and their registers are not built; all other behaviour is identical.

Structure
REQ-030 Shared package armstrong_pkg holds:
- the state enum typedef;
- NUM_W and DATA_W defaults;
- a STROBE_IDLE constant (3'b111).
REQ-031 Sub-module armstrong_bus_seq owns the state machine, the compute counter and the strobe generation; the top level holds the range, number and hit-count registers.

Verification
REQ-032 Bench pairs this block with a behavioural Armstrong peripheral model using COMPUTE_CYCLES=3.
- Scan range 150..160 -> hit_count=1, single hit_valid with hit_number=153, done after 67 cycles.
- Scan range 0..1023 -> hit_count=6; hits 0, 1, 153, 370, 371, 407 in that order; no wrap; one done.
REQ-033 start with range_lo=20, range_hi=10 -> done on the next cycle, hit_count=0, no strobe ever asserted.
REQ-034 start with range 370..371, plus a second start mid-scan -> second start ignored; hit_count=2; strobe sequence per number is W, C, C, C, R, -.
REQ-035 reset asserted during COMPUTE of a 0..1023 scan -> strobes=1 before the next clock edge, busy=0, hit_count=0; a new start runs normally.
REQ-036 Compile without ARMSTRONG_HIT_REPORT_EN and scan 0..1023 -> hit_valid and hit_number constant 0, hit_count=6.
